// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/shift step per clock over WIDTH+1-bit
// extended operands, with a start/busy/done handshake and a held hi/low result.
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] value_A_Mc,
    input  logic [WIDTH-1:0] value_B_Mp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] low
);

    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(E + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [E-1:0]     a_q, a_d;
    logic [E-1:0]     q_q, q_d;
    logic             q1_q, q1_d;
    logic [E-1:0]     m_q, m_d;
    logic [E-1:0]     negm_q, negm_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic             done_q, done_d;

    logic [E-1:0]     mcExt;
    logic [E-1:0]     mpExt;
    logic [E-1:0]     sum;

    // The extra bit lets one signed Booth datapath serve unsigned operands too.
    always_comb begin
        mcExt = is_signed ? {value_A_Mc[WIDTH-1], value_A_Mc} : {1'b0, value_A_Mc};
        mpExt = is_signed ? {value_B_Mp[WIDTH-1], value_B_Mp} : {1'b0, value_B_Mp};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        negm_d  = negm_q;
        hi_d    = hi_q;
        low_d   = low_q;
        done_d  = 1'b0;
        sum     = a_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = '0;
                    q_d     = mpExt;
                    q1_d    = 1'b0;
                    m_d     = mcExt;
                    negm_d  = {E{1'b0}} - mcExt;
                end
            end
            RUN: begin
                case ({q_q[0], q1_q})
                    2'b10:   sum = a_q + negm_q;
                    2'b01:   sum = a_q + m_q;
                    default: sum = a_q;
                endcase
                a_d   = {sum[E-1], sum[E-1:1]};
                q_d   = {sum[0], q_q[E-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                // Product bits [2W-1:W] straddle the A/Q boundary after the last shift.
                if (cnt_q == CW'(E - 1)) begin
                    hi_d    = {a_d[WIDTH-2:0], q_d[WIDTH]};
                    low_d   = q_d[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            negm_q  <= '0;
            hi_q    <= '0;
            low_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            negm_q  <= negm_d;
            hi_q    <= hi_d;
            low_q   <= low_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign low  = low_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=32 and WIDTH=8, with an arithmetic
// reference model, done-latency tracking and hi/low hold checking.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start32, signed32, busy32, done32;
    logic [31:0] a32, b32, hi32, low32;
    logic        start8, signed8, busy8, done8;
    logic [7:0]  a8, b8, hi8, low8;

    booth_mult_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .is_signed(signed32),
        .value_A_Mc(a32), .value_B_Mp(b32),
        .busy(busy32), .done(done32), .hi(hi32), .low(low32)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(signed8),
        .value_A_Mc(a8), .value_B_Mp(b8),
        .busy(busy8), .done(done8), .hi(hi8), .low(low8)
    );

    typedef struct {
        logic [63:0] prod;
        int          doneCyc;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    logic [63:0] held32 = '0;
    logic [63:0] held8  = '0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] refMul32(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    function automatic logic [15:0] refMul8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
        if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end else begin
            sa = int'({24'b0, a});
            sb = int'({24'b0, b});
        end
        return 16'(sa * sb);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Called right after a negedge; start is sampled at the following posedge.
    task automatic applyStimulus32(input logic s, input logic [31:0] a, input logic [31:0] b,
                                   input bit accept, input logic [63:0] expProd);
        exp_t e;
        start32 = 1'b1; signed32 = s; a32 = a; b32 = b;
        if (accept) begin
            e.prod = expProd;
            e.doneCyc = cyc + 1 + 33;
            q32.push_back(e);
        end
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic applyStimulus8(input logic s, input logic [7:0] a, input logic [7:0] b,
                                  input logic [15:0] expProd);
        exp_t e;
        start8 = 1'b1; signed8 = s; a8 = a; b8 = b;
        e.prod = {48'b0, expProd};
        e.doneCyc = cyc + 1 + 9;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic waitIdle32();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy32 && n < 200);
        if (busy32) timeoutFail("waitIdle32");
    endtask

    task automatic waitDone32();
        int n = 0;
        do begin @(negedge clk); n++; end while (!done32 && n < 200);
        if (!done32) timeoutFail("waitDone32");
    endtask

    task automatic waitIdle8();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy8 && n < 200);
        if (busy8) timeoutFail("waitIdle8");
    endtask

    task automatic waitDone8();
        int n = 0;
        do begin @(negedge clk); n++; end while (!done8 && n < 200);
        if (!done8) timeoutFail("waitDone8");
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (done32) begin
                if (q32.size() == 0) timeoutFail("unexpected_done32");
                else begin
                    e = q32.pop_front();
                    checkOutput("prod32", {hi32, low32}, e.prod);
                    checkOutput("done32_cycle", 64'(cyc), 64'(e.doneCyc));
                    held32 = e.prod;
                end
            end else checkOutput("hold32", {hi32, low32}, held32);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (done8) begin
                if (q8.size() == 0) timeoutFail("unexpected_done8");
                else begin
                    e = q8.pop_front();
                    checkOutput("prod8", {48'b0, hi8, low8}, e.prod);
                    checkOutput("done8_cycle", 64'(cyc), 64'(e.doneCyc));
                    held8 = e.prod;
                end
            end else checkOutput("hold8", {48'b0, hi8, low8}, held8);
        end
    end

    initial begin
        logic        s;
        logic [31:0] ra, rb;
        logic [7:0]  ra8, rb8;
        int          n;

        reset = 1'b1;
        start32 = 1'b0; signed32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0; signed8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy32", {63'b0, busy32}, 64'd0);
        checkOutput("reset_done32", {63'b0, done32}, 64'd0);
        checkOutput("reset_hilo32", {hi32, low32}, 64'd0);
        checkOutput("reset_hilo8", {48'b0, hi8, low8}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed: -7 * 3, with busy length measured.
        applyStimulus32(1'b1, 32'hFFFFFFF9, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFEB);
        n = 1;
        @(negedge clk);
        while (busy32 && n < 100) begin n++; @(negedge clk); end
        checkOutput("busy32_cycles", 64'(n), 64'd33);

        waitIdle32();
        applyStimulus32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001);
        waitIdle32();
        applyStimulus32(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
        waitIdle32();
        applyStimulus32(1'b1, 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
        waitIdle32();
        applyStimulus32(1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC0000000_80000000);

        // Start while busy must be dropped; start in the done cycle must be taken.
        waitIdle32();
        applyStimulus32(1'b0, 32'd5, 32'd6, 1'b1, 64'd30);
        repeat (8) @(negedge clk);
        checkOutput("busy32_midrun", {63'b0, busy32}, 64'd1);
        applyStimulus32(1'b0, 32'd9, 32'd9, 1'b0, 64'd0);
        waitDone32();
        applyStimulus32(1'b0, 32'd9, 32'd9, 1'b1, 64'd81);

        // Reset in the middle of a run.
        waitIdle32();
        applyStimulus32(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b1, 64'd0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        held32 = '0;
        held8 = '0;
        #1;
        checkOutput("abort_busy32", {63'b0, busy32}, 64'd0);
        checkOutput("abort_hilo32", {hi32, low32}, 64'd0);
        q32.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus32(1'b1, 32'hFFFFFFF9, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFEB);

        // Randomised back-to-back runs, mixing in corner operands.
        waitIdle32();
        applyStimulus32(1'b0, 32'd1, 32'd1, 1'b1, 64'd1);
        for (int i = 0; i < 30; i++) begin
            s  = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 3) ra = 32'h80000000;
            if (i % 5 == 2) rb = 32'hFFFFFFFF;
            if (i % 11 == 4) ra = 32'h0;
            waitDone32();
            applyStimulus32(s, ra, rb, 1'b1, refMul32(s, ra, rb));
        end
        waitIdle32();

        // WIDTH=8 instance.
        applyStimulus8(1'b0, 8'd200, 8'd200, 16'h9C40);
        waitIdle8();
        applyStimulus8(1'b1, 8'h80, 8'hFF, 16'h0080);
        waitIdle8();
        applyStimulus8(1'b1, 8'h80, 8'h80, 16'h4000);
        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            if (i % 6 == 1) ra8 = 8'hFF;
            waitDone8();
            applyStimulus8(s, ra8, rb8, refMul8(s, ra8, rb8));
        end

        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q32.size() != 0) timeoutFail("drain_q32");
        if (q8.size() != 0) timeoutFail("drain_q8");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
